// File: rtl/pattern_scan_pkg.sv
// Shared state encoding and default sizes for the pattern scan controller.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int PAT_W_DEF = 4;
  localparam int WIN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/pattern_shift_match.sv
// Serial history of the last PAT_W-1 bits; o_match compares the window that
// includes the incoming bit, so a match is visible in the cycle the bit arrives.
module pattern_shift_match
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_match,
  output logic             o_primed
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_window;

  // The oldest window bit ages out on the next shift, so only PAT_W-1 bits are stored.
  assign w_window = {r_hist, i_bit};
  assign o_match  = (w_window == i_pattern);
  assign o_primed = (r_fill >= FILL_W'(PAT_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_window[PAT_W-2:0];
      if (!o_primed) r_fill <= r_fill + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Arms, sequences and reports a serial pattern scan over a bounded window,
// counting overlapping matches with a saturating hit counter.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [WIN_W-1:0] win_len,
  input  logic             d_in,
  input  logic             d_valid,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             overflow,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] r_n, w_n_nxt, w_n_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy, r_hit, r_ovf, r_done;
  logic             w_busy_nxt, w_hit_nxt, w_ovf_nxt, w_done_nxt;
  logic             w_latch, w_clr, w_shift, w_match, w_primed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pattern_shift_match #(.PAT_W(PAT_W)) u_match (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_shift  (w_shift),
    .i_bit    (d_in),
    .i_pattern(r_pat),
    .o_match  (w_match),
    .o_primed (w_primed)
  );

  assign w_n_inc = r_n + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_busy_nxt  = 1'b0;
    w_hit_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_latch   = 1'b1;
          w_clr     = 1'b1;
          w_n_nxt   = '0;
          w_cnt_nxt = '0;
          w_ovf_nxt = 1'b0;
          if (win_len == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_SCAN;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        w_busy_nxt = 1'b1;
        // Abort takes priority and drops any match carried by this cycle's bit.
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (d_valid) begin
          w_shift = 1'b1;
          w_n_nxt = w_n_inc;
          if (w_match && w_primed) begin
            w_hit_nxt = 1'b1;
            w_cnt_nxt = sat_inc(r_cnt);
            w_ovf_nxt = r_ovf | (&r_cnt);
          end
          if (w_n_inc == r_win) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hit   <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_hit   <= w_hit_nxt;
      r_ovf   <= w_ovf_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Scan configuration is data only; it is always written before first use.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_pat <= pattern;
      r_win <= win_len;
    end
  end

  assign busy     = r_busy;
  assign hit      = r_hit;
  assign hit_cnt  = r_cnt;
  assign overflow = r_ovf;
  assign done     = r_done;

endmodule
